// File: rtl/alu_seq.sv
// alu_seq: sequential ALU feeding the register-file write port, with a
// Z/N/C/V flag register and an optional shift-add multiplier.
// Ports: clk, rst (async, active-high); a, b, op, start in;
//   result, wr_en, wr_hi, busy, done, flags {Z,N,C,V} out.
// Define ALU_MUL_EN to build op 14 as an 8-iteration unsigned multiply;
// otherwise op 14 is treated as reserved and wr_hi is held low.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    input  logic             start,
    output logic [WIDTH-1:0] result,
    output logic             wr_en,
    output logic             wr_hi,
    output logic             busy,
    output logic             done,
    output logic [3:0]       flags
);

    localparam int MSB = WIDTH - 1;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_ADC = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_SBC = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_NOT = 4'd7;
    localparam logic [3:0] OP_SHL = 4'd8;
    localparam logic [3:0] OP_SHR = 4'd9;
    localparam logic [3:0] OP_ROL = 4'd10;
    localparam logic [3:0] OP_ROR = 4'd11;
    localparam logic [3:0] OP_CMP = 4'd12;
    localparam logic [3:0] OP_MOV = 4'd13;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_EXEC = 3'd1
`ifdef ALU_MUL_EN
        ,
        S_MUL  = 3'd2,
        S_WRLO = 3'd3,
        S_WRHI = 3'd4
`endif
    } state_t;

    state_t state, next;

    logic [WIDTH-1:0] a_q, b_q;
    logic [3:0]       op_q;

`ifdef ALU_MUL_EN
    localparam logic [3:0] OP_MUL = 4'd14;
    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] prod;
    logic [CW-1:0]      cnt;
    logic [WIDTH:0]     psum;

    // Low half of prod holds the unconsumed multiplier bits; the
    // partial sum lands in the high half and everything shifts right.
    assign psum = {1'b0, prod[2*WIDTH-1:WIDTH]}
                + (prod[0] ? {1'b0, a_q} : '0);
`endif

    // Single-cycle datapath, evaluated on the latched operands.
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v, cin, add_cin, sub_cin;
    logic             upd_flags, wr_op;

    assign cin     = flags[1];
    assign add_cin = (op_q == OP_ADC) & cin;
    assign sub_cin = (op_q == OP_SBC) & cin;

    // Ops 14/15 never touch the flags from EXEC; CMP and reserved
    // ops never write back.
    assign upd_flags = (op_q < 4'd14);
    assign wr_op     = (op_q < OP_CMP) || (op_q == OP_MOV);

    always_comb begin
        sum     = '0;
        alu_res = '0;
        alu_c   = cin;
        alu_v   = 1'b0;
        case (op_q)
            OP_ADD, OP_ADC: begin
                sum     = {1'b0, a_q} + {1'b0, b_q}
                        + {{WIDTH{1'b0}}, add_cin};
                alu_res = sum[MSB:0];
                alu_c   = sum[WIDTH];
                alu_v   = (a_q[MSB] == b_q[MSB])
                        && (sum[MSB] != a_q[MSB]);
            end
            OP_SUB, OP_SBC, OP_CMP: begin
                // Top bit of the widened difference is the borrow.
                sum     = {1'b0, a_q} - {1'b0, b_q}
                        - {{WIDTH{1'b0}}, sub_cin};
                alu_res = sum[MSB:0];
                alu_c   = sum[WIDTH];
                alu_v   = (a_q[MSB] != b_q[MSB])
                        && (sum[MSB] != a_q[MSB]);
            end
            OP_AND: alu_res = a_q & b_q;
            OP_OR:  alu_res = a_q | b_q;
            OP_XOR: alu_res = a_q ^ b_q;
            OP_NOT: alu_res = ~a_q;
            OP_MOV: alu_res = b_q;
            OP_SHL: begin
                alu_res = {a_q[MSB-1:0], 1'b0};
                alu_c   = a_q[MSB];
            end
            OP_SHR: begin
                alu_res = {1'b0, a_q[MSB:1]};
                alu_c   = a_q[0];
            end
            OP_ROL: begin
                alu_res = {a_q[MSB-1:0], cin};
                alu_c   = a_q[MSB];
            end
            OP_ROR: begin
                alu_res = {cin, a_q[MSB:1]};
                alu_c   = a_q[0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= next;
    end

    // Outputs decode only registered state, never the live inputs.
    always_comb begin
        next   = state;
        result = '0;
        wr_en  = 1'b0;
        wr_hi  = 1'b0;
        busy   = 1'b1;
        done   = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
`ifdef ALU_MUL_EN
                    next = (op == OP_MUL) ? S_MUL : S_EXEC;
`else
                    next = S_EXEC;
`endif
                end
            end
            S_EXEC: begin
                result = wr_op ? alu_res : '0;
                wr_en  = wr_op;
                done   = 1'b1;
                next   = S_IDLE;
            end
`ifdef ALU_MUL_EN
            S_MUL: begin
                if (cnt == CW'(WIDTH - 1)) next = S_WRLO;
            end
            S_WRLO: begin
                result = prod[MSB:0];
                wr_en  = 1'b1;
                next   = S_WRHI;
            end
            S_WRHI: begin
                result = prod[2*WIDTH-1:WIDTH];
                wr_en  = 1'b1;
                wr_hi  = 1'b1;
                done   = 1'b1;
                next   = S_IDLE;
            end
`endif
            default: next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            flags <= '0;
`ifdef ALU_MUL_EN
            prod  <= '0;
            cnt   <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_q  <= a;
                        b_q  <= b;
                        op_q <= op;
`ifdef ALU_MUL_EN
                        prod <= {{WIDTH{1'b0}}, b};
                        cnt  <= '0;
`endif
                    end
                end
                S_EXEC: begin
                    if (upd_flags)
                        flags <= {~|alu_res, alu_res[MSB],
                                  alu_c, alu_v};
                end
`ifdef ALU_MUL_EN
                S_MUL: begin
                    prod <= {psum, prod[MSB:1]};
                    cnt  <= cnt + CW'(1);
                end
                S_WRHI: begin
                    flags <= {~|prod, prod[2*WIDTH-1],
                              |prod[2*WIDTH-1:WIDTH], 1'b0};
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq (vector table, scoreboard
// of expected write-backs, hand-written multi-cycle sequences).
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a, b;
    logic [3:0] op;
    logic       start;
    logic [7:0] result;
    logic       wr_en, wr_hi, busy, done;
    logic [3:0] flags;

    always #5 clk = ~clk;

    alu_seq dut (
        .clk    (clk),
        .rst    (rst),
        .a      (a),
        .b      (b),
        .op     (op),
        .start  (start),
        .result (result),
        .wr_en  (wr_en),
        .wr_hi  (wr_hi),
        .busy   (busy),
        .done   (done),
        .flags  (flags)
    );

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       wr;
        logic [3:0] fl;
    } vec_t;

    typedef struct {
        logic [7:0] res;
        logic       hi;
    } wb_t;

    wb_t  sbq[$];
    int   checks   = 0;
    int   failures = 0;
    vec_t vt[18];

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_wb(input logic [7:0] r, input logic h);
        wb_t e;
        e.res = r;
        e.hi  = h;
        sbq.push_back(e);
    endtask

    // Every write strobe must match the oldest expected write-back.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: result %h wr_hi %b, none expected",
                         result, wr_hi);
            end else begin
                wb_t e;
                e = sbq.pop_front();
                chk("writeback", {7'd0, wr_hi, result}, {7'd0, e.hi, e.res});
            end
        end
    end

    task automatic run_vec(input vec_t v, input string tag);
        @(negedge clk);
        a = v.a; b = v.b; op = v.op; start = 1'b1;
        if (v.wr) push_wb(v.res, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); op = 4'($urandom);
        @(negedge clk);
        chk($sformatf("%s_busy", tag), 16'(busy), 16'd1);
        chk($sformatf("%s_done", tag), 16'(done), 16'd1);
        chk($sformatf("%s_wr_en", tag), 16'(wr_en), 16'(v.wr));
        chk($sformatf("%s_wr_hi", tag), 16'(wr_hi), 16'd0);
        @(negedge clk);
        chk($sformatf("%s_flags", tag), 16'(flags), 16'(v.fl));
        chk($sformatf("%s_idle", tag), 16'({busy, done}), 16'd0);
    endtask

`ifdef ALU_MUL_EN
    task automatic mul_run(input logic [7:0] ma, input logic [7:0] mb,
                           input logic [7:0] lo, input logic [7:0] hi,
                           input logic [3:0] fl, input string tag);
        @(negedge clk);
        a = ma; b = mb; op = 4'd14; start = 1'b1;
        push_wb(lo, 1'b0);
        push_wb(hi, 1'b1);
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom);
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (k <= 10) begin
                chk($sformatf("%s_busy_c%0d", tag, k), 16'(busy), 16'd1);
                chk($sformatf("%s_done_c%0d", tag, k), 16'(done), 16'(k == 10));
                chk($sformatf("%s_wr_c%0d", tag, k), 16'(wr_en), 16'(k >= 9));
                chk($sformatf("%s_hi_c%0d", tag, k), 16'(wr_hi), 16'(k == 10));
            end else begin
                chk($sformatf("%s_flags", tag), 16'(flags), 16'(fl));
                chk($sformatf("%s_idle", tag), 16'(busy), 16'd0);
            end
            // a start while busy must be dropped, not queued
            if (k == 2) begin
                start = 1'b1; a = 8'h11; b = 8'h22; op = 4'd0;
            end
            if (k == 3) start = 1'b0;
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{4'd0,  8'h7F, 8'h01, 8'h80, 1'b1, 4'b0101};
        vt[1]  = '{4'd2,  8'h00, 8'h01, 8'hFF, 1'b1, 4'b0110};
        vt[2]  = '{4'd3,  8'h05, 8'h02, 8'h02, 1'b1, 4'b0000};
        vt[3]  = '{4'd12, 8'h42, 8'h42, 8'h00, 1'b0, 4'b1000};
        vt[4]  = '{4'd0,  8'hFF, 8'h01, 8'h00, 1'b1, 4'b1010};
        vt[5]  = '{4'd4,  8'hF0, 8'h3C, 8'h30, 1'b1, 4'b0010};
        vt[6]  = '{4'd5,  8'h0F, 8'h80, 8'h8F, 1'b1, 4'b0110};
        vt[7]  = '{4'd1,  8'h10, 8'h20, 8'h31, 1'b1, 4'b0000};
        vt[8]  = '{4'd6,  8'hAA, 8'hAA, 8'h00, 1'b1, 4'b1000};
        vt[9]  = '{4'd7,  8'h55, 8'h00, 8'hAA, 1'b1, 4'b0100};
        vt[10] = '{4'd8,  8'h81, 8'h00, 8'h02, 1'b1, 4'b0010};
        vt[11] = '{4'd10, 8'h40, 8'h00, 8'h81, 1'b1, 4'b0100};
        vt[12] = '{4'd9,  8'h03, 8'h00, 8'h01, 1'b1, 4'b0010};
        vt[13] = '{4'd11, 8'h02, 8'h00, 8'h81, 1'b1, 4'b0100};
        vt[14] = '{4'd13, 8'h99, 8'h00, 8'h00, 1'b1, 4'b1000};
        vt[15] = '{4'd2,  8'h80, 8'h01, 8'h7F, 1'b1, 4'b0001};
        vt[16] = '{4'd15, 8'h12, 8'h34, 8'h00, 1'b0, 4'b0001};
        vt[17] = '{4'd3,  8'h00, 8'h00, 8'h00, 1'b1, 4'b1000};

        rst = 1'b1; start = 1'b0; a = '0; b = '0; op = '0;
        repeat (3) @(negedge clk);
        chk("rst_result", 16'(result), 16'd0);
        chk("rst_wr_en", 16'(wr_en), 16'd0);
        chk("rst_wr_hi", 16'(wr_hi), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_done", 16'(done), 16'd0);
        chk("rst_flags", 16'(flags), 16'd0);
        rst = 1'b0;

        for (int i = 0; i < 18; i++)
            run_vec(vt[i], $sformatf("vec%0d", i));

`ifndef ALU_MUL_EN
        run_vec('{4'd14, 8'h03, 8'h05, 8'h00, 1'b0, 4'b1000}, "op14_rsv");
`endif

        // start held high: ignored while done pulses, taken next idle cycle
        @(negedge clk);
        op = 4'd0; a = 8'h01; b = 8'h01; start = 1'b1;
        push_wb(8'h02, 1'b0);
        @(posedge clk);
        #1;
        a = 8'h02; b = 8'h02;
        @(negedge clk);
        chk("hold_done1", 16'(done), 16'd1);
        push_wb(8'h04, 1'b0);
        @(negedge clk);
        chk("hold_idle_gap", 16'(busy), 16'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("hold_done2", 16'(done), 16'd1);
        chk("hold_wr2", 16'(wr_en), 16'd1);
        @(negedge clk);
        chk("hold_flags", 16'(flags), 16'd0);

`ifdef ALU_MUL_EN
        mul_run(8'h0C, 8'h0A, 8'h78, 8'h00, 4'b0000, "mul_0c0a");
        mul_run(8'h00, 8'h37, 8'h00, 8'h00, 4'b1000, "mul_zero");
        mul_run(8'hFF, 8'hFF, 8'h01, 8'hFE, 4'b0110, "mul_ffff");
`endif

        // leave C set so a missed flag reset is visible through ADC
        run_vec('{4'd2, 8'h00, 8'h01, 8'hFF, 1'b1, 4'b0110}, "pre_rst");

        @(negedge clk);
`ifdef ALU_MUL_EN
        op = 4'd14; a = 8'h0C; b = 8'h0A; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
`else
        op = 4'd0; a = 8'h10; b = 8'h20; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        rst = 1'b1;
`endif
        #1;
        chk("midrst_result", 16'(result), 16'd0);
        chk("midrst_wr_en", 16'(wr_en), 16'd0);
        chk("midrst_wr_hi", 16'(wr_hi), 16'd0);
        chk("midrst_busy", 16'(busy), 16'd0);
        chk("midrst_done", 16'(done), 16'd0);
        chk("midrst_flags", 16'(flags), 16'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);

        run_vec('{4'd1, 8'h03, 8'h04, 8'h07, 1'b1, 4'b0000}, "post_rst_adc");
`ifdef ALU_MUL_EN
        mul_run(8'hFF, 8'hFF, 8'h01, 8'hFE, 4'b0110, "post_rst_mul");
`endif

        repeat (2) @(negedge clk);
        chk("sb_empty", 16'(sbq.size()), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
